multiplicador_shift_add: RTL and testbench

//  Sequential 8x8 unsigned shift-and-add multiplier; produces a 16-bit product in 8 iterations.

---
 rtl/multiplicador_shift_add_pkg.sv | 20 ++
 rtl/somador16bits.sv | 32 +++
 rtl/multiplicador_shift_add.sv | 93 +++++++++
 tb/tb_multiplicador_shift_add.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/multiplicador_shift_add_pkg.sv
// Shared widths, FSM state encoding and the 1-bit full-adder cell
// used by the 8+16 ripple adder of the shift-and-add multiplier.
package multiplicador_shift_add_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned PROD_W = 2 * N;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full adder cell: returns {carry_out, sum}
  function automatic logic [1:0] somadorcompleto(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/somador16bits.sv
// Ripple-carry adder: 8-bit operand a (zero-extended) plus 16-bit operand b,
// built from a chain of somadorcompleto cells.
module somador16bits
  import multiplicador_shift_add_pkg::*;
(
  input  logic [N-1:0]      i_a,
  input  logic [PROD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [PROD_W-1:0] o_sum,
  output logic              o_cout
);

  logic [PROD_W-1:0] w_a_ext;

  assign w_a_ext = PROD_W'(i_a);

  // Carry ripples LSB to MSB through one cell per bit
  always_comb begin : ripple
    logic       w_c;
    logic [1:0] w_fa;
    w_c   = i_cin;
    w_fa  = 2'b00;
    o_sum = '0;
    for (int i = 0; i < PROD_W; i++) begin
      w_fa     = somadorcompleto(w_a_ext[i], i_b[i], w_c);
      o_sum[i] = w_fa[0];
      w_c      = w_fa[1];
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/multiplicador_shift_add.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one add/shift iteration
// per clock through somador16bits, 16-bit product after 8 iterations.
module multiplicador_shift_add
  import multiplicador_shift_add_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [N-1:0]      multiplicando,
  input  logic [N-1:0]      multiplicador,
  output logic [PROD_W-1:0] produto,
  output logic              pronto,
  output logic              ocupado
);

  state_t              r_state;
  logic [N-1:0]        r_mcand;
  logic [PROD_W-1:0]   r_p;
  logic [CNT_W-1:0]    r_count;
  logic [PROD_W-1:0]   r_produto;
  logic                r_pronto;
  logic                r_ocupado;

  logic [PROD_W-1:0]   w_b;
  logic [PROD_W-1:0]   w_sum;
  logic                w_cout;
  logic                w_unused_adder;

  // Adder sees mcand + high half of P; the partial sum fits in 9 bits
  assign w_b = PROD_W'(r_p[PROD_W-1:N]);

  somador16bits u_somador (
    .i_a    (r_mcand),
    .i_b    (w_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_unused_adder = ^{w_cout, w_sum[PROD_W-1:N+1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_p       <= '0;
      r_count   <= '0;
      r_produto <= '0;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iniciar) begin
            r_mcand   <= multiplicando;
            r_p       <= {N'(0), multiplicador};
            r_count   <= '0;
            r_ocupado <= 1'b1;
            r_state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Multiplier bit 0 selects add-then-shift or plain shift
          if (r_p[0]) begin
            r_p <= {w_sum[N:0], r_p[N-1:1]};
          end else begin
            r_p <= r_p >> 1;
          end
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(N - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_produto <= r_p;
          r_pronto  <= 1'b1;
          r_ocupado <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_ocupado <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign produto = r_produto;
  assign pronto  = r_pronto;
  assign ocupado = r_ocupado;

endmodule

// File: tb/tb_multiplicador_shift_add.sv
// Self-checking bench for multiplicador_shift_add: directed cases plus random
// operands, checked against plain A*B and the start-to-pronto timing.
module tb_multiplicador_shift_add;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic [15:0] produto;
  logic        pronto;
  logic        ocupado;

  int total = 0;
  int bad   = 0;

  multiplicador_shift_add dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .produto       (produto),
    .pronto        (pronto),
    .ocupado       (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse iniciar for one edge; returns at the negedge right after the capture edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    multiplicando = a;
    multiplicador = b;
    iniciar       = 1'b1;
    @(negedge clock);
    iniciar       = 1'b0;
    multiplicando = 8'($urandom);
    multiplicador = 8'($urandom);
  endtask

  // Wait (bounded) for pronto; cyc counts negedges since the capture edge
  task automatic wait_result(input string tag, input logic [15:0] exp, input int start_cyc);
    int cyc  = start_cyc;
    int busy = 0;
    bit seen = 1'b0;
    while (cyc < 20 && !seen) begin
      if (pronto) begin
        seen = 1'b1;
      end else begin
        if (ocupado) busy++;
        @(negedge clock);
        cyc++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd9);
    chk({tag, "_busy"}, 32'(busy), 32'(9 - start_cyc));
    chk({tag, "_produto"}, 32'(produto), 32'(exp));
    chk({tag, "_ocupado_at_pronto"}, 32'(ocupado), 32'd0);
    @(negedge clock);
    chk({tag, "_pronto_one_cycle"}, 32'(pronto), 32'd0);
    chk({tag, "_produto_held"}, 32'(produto), 32'(exp));
  endtask

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] q[$];
    logic [15:0] expv;
    int          spurious;

    reset         = 1'b1;
    iniciar       = 1'b0;
    multiplicando = 8'h00;
    multiplicador = 8'h00;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_produto", 32'(produto), 32'h0);
    chk("rst_pronto", 32'(pronto), 32'h0);
    chk("rst_ocupado", 32'(ocupado), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_produto", 32'(produto), 32'h0);
    chk("idle_pronto", 32'(pronto), 32'h0);
    chk("idle_ocupado", 32'(ocupado), 32'h0);

    // Basic and boundary products
    start_op(8'h0D, 8'h0B); wait_result("p0d_0b", 16'h008F, 0);
    start_op(8'hFF, 8'hFF); wait_result("pff_ff", 16'hFE01, 0);
    start_op(8'h00, 8'hAB); wait_result("p00_ab", 16'h0000, 0);
    start_op(8'hAB, 8'h00); wait_result("pab_00", 16'h0000, 0);
    start_op(8'h01, 8'h80); wait_result("p01_80", 16'h0080, 0);

    // iniciar during CALC must be ignored
    start_op(8'h12, 8'h34);
    @(negedge clock);
    @(negedge clock);
    multiplicando = 8'h99;
    multiplicador = 8'h99;
    iniciar       = 1'b1;
    @(negedge clock);
    iniciar       = 1'b0;
    wait_result("ignored_start", 16'h03A8, 3);

    // Reset mid-CALC aborts with no pronto
    start_op(8'hFF, 8'hFF);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ocupado", 32'(ocupado), 32'h0);
    chk("abort_pronto", 32'(pronto), 32'h0);
    chk("abort_produto", 32'(produto), 32'h0);
    spurious = 0;
    repeat (12) begin
      @(negedge clock);
      if (pronto || ocupado) spurious++;
    end
    chk("abort_no_pronto", 32'(spurious), 32'd0);
    start_op(8'h02, 8'h03); wait_result("after_abort", 16'h0006, 0);

    // Random isolated operations against A*B
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb);
      wait_result($sformatf("rand%0d", n), 16'(ra) * 16'(rb), 0);
    end

    // iniciar held high: new capture every 10 cycles, operands change every cycle
    repeat (2) @(negedge clock);
    for (int t = 0; t <= 60; t++) begin
      if (t > 0 && (t % 10) == 0) begin
        expv = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        chk($sformatf("b2b_pronto_t%0d", t), 32'(pronto), 32'd1);
        chk($sformatf("b2b_produto_t%0d", t), 32'(produto), 32'(expv));
      end else if (t > 0) begin
        chk($sformatf("b2b_nopronto_t%0d", t), 32'(pronto), 32'd0);
      end
      multiplicando = 8'($urandom);
      multiplicador = 8'($urandom);
      iniciar       = (t < 60);
      if ((t % 10) == 0 && t < 60) q.push_back(16'(multiplicando) * 16'(multiplicador));
      @(negedge clock);
    end
    iniciar = 1'b0;
    repeat (12) @(negedge clock);
    chk("final_idle", 32'(ocupado), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
